// File: rtl/screen_scan_ctrl_if.sv
// screen_scan_ctrl_if: framebuffer read port and LED panel pins of the scan sequencer.
// SCREEN_DBUF_EN adds swap_req/swap_ack and widens fb_addr with the front-buffer bit.
interface screen_scan_ctrl_if #(parameter int BPC = 4);
`ifdef SCREEN_DBUF_EN
  localparam int AW = 10;
`else
  localparam int AW = 9;
`endif
  logic enable;
  logic fb_rd;
  logic [AW-1:0] fb_addr;
  logic [6*BPC-1:0] fb_rdata;
  logic [5:0] panel_rgb;
  logic [3:0] panel_addr;
  logic panel_clk;
  logic panel_lat;
  logic panel_oe_n;
  logic frame_done;
`ifdef SCREEN_DBUF_EN
  logic swap_req;
  logic swap_ack;
  modport master (input enable, fb_rdata, swap_req,
                  output fb_rd, fb_addr, panel_rgb, panel_addr, panel_clk, panel_lat, panel_oe_n, frame_done, swap_ack);
  modport slave (output enable, fb_rdata, swap_req,
                 input fb_rd, fb_addr, panel_rgb, panel_addr, panel_clk, panel_lat, panel_oe_n, frame_done, swap_ack);
`else
  modport master (input enable, fb_rdata,
                  output fb_rd, fb_addr, panel_rgb, panel_addr, panel_clk, panel_lat, panel_oe_n, frame_done);
  modport slave (output enable, fb_rdata,
                 input fb_rd, fb_addr, panel_rgb, panel_addr, panel_clk, panel_lat, panel_oe_n, frame_done);
`endif
endinterface

// File: rtl/screen_scan_ctrl.sv
// screen_scan_ctrl: 1/16-scan 32x32 LED panel sequencer with binary-weighted bit-plane OE timing.
// Optional SCREEN_DBUF_EN: double-buffered framebuffer, swapped only at frame boundaries.
module screen_scan_ctrl #(
  parameter int BPC = 4,
  parameter int BASE_TIME = 32
) (
  input logic clk,
  input logic reset,
  screen_scan_ctrl_if.master bus
);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, SHIFT = 3'd2, LATCH = 3'd3, DISPLAY = 3'd4;
  localparam int PW = BPC > 1 ? $clog2(BPC) : 1;
  localparam int DW = $clog2(BASE_TIME << (BPC - 1)) + 1;
  logic [2:0] state, state_nx;
  logic [3:0] row, paddr;
  logic [PW-1:0] plane;
  logic [5:0] cnt, sel, rgb_q;
  logic [DW-1:0] dcnt, disp_len;
  logic [BPC-1:0] ch [6];
  logic disp_last, plane_last, shift_odd;
  logic [4:0] col_rd;
  for (genvar i = 0; i < 6; i++) begin : g_ch
    assign ch[i] = bus.fb_rdata[i*BPC +: BPC];
    assign sel[i] = ch[i][plane];
  end
  assign disp_len = DW'((BASE_TIME << plane) - 1);
  assign disp_last = state == DISPLAY && dcnt == disp_len;
  assign plane_last = plane == PW'(BPC - 1);
  assign shift_odd = state == SHIFT && cnt[0];
  // Column c+1 is requested on the odd half of column c so its data lands on the next even cycle.
  assign col_rd = state == SHIFT ? cnt[5:1] + 5'd1 : 5'd0;
  assign bus.fb_rd = state == FETCH || (shift_odd && cnt != 6'd63);
  assign bus.panel_rgb = state == SHIFT && !cnt[0] ? sel : rgb_q;
  assign bus.panel_addr = paddr;
  assign bus.panel_clk = shift_odd;
  assign bus.panel_lat = state == LATCH;
  assign bus.panel_oe_n = state != DISPLAY;
  assign bus.frame_done = disp_last && plane_last && row == 4'd15;
  always_comb begin
    state_nx = state == IDLE ? FETCH :
               state == FETCH ? SHIFT :
               state == SHIFT ? (cnt == 6'd63 ? LATCH : SHIFT) :
               state == LATCH ? DISPLAY :
               disp_last ? FETCH : DISPLAY;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      row <= '0;
      plane <= '0;
      cnt <= '0;
      dcnt <= '0;
      rgb_q <= '0;
      paddr <= '0;
    end else if (!bus.enable) begin
      state <= IDLE;
      row <= '0;
      plane <= '0;
      cnt <= '0;
      dcnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= state == SHIFT && cnt != 6'd63 ? cnt + 6'd1 : 6'd0;
      dcnt <= state == DISPLAY && !disp_last ? dcnt + DW'(1) : '0;
      if (state == SHIFT && !cnt[0]) rgb_q <= sel;
      if (state == LATCH) paddr <= row;
      if (disp_last) begin
        plane <= plane_last ? '0 : plane + PW'(1);
        if (plane_last) row <= row == 4'd15 ? 4'd0 : row + 4'd1;
      end
    end
  end
`ifdef SCREEN_DBUF_EN
  logic front, pending;
  assign bus.swap_ack = bus.frame_done && pending;
  assign bus.fb_addr = {front, row, col_rd};
  always_ff @(posedge clk) begin
    if (reset) begin
      front <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (bus.swap_ack) front <= ~front;
      pending <= bus.swap_ack ? bus.swap_req : pending | bus.swap_req;
    end
  end
`else
  assign bus.fb_addr = {row, col_rd};
`endif
endmodule

// File: tb/tb_screen_scan_ctrl.sv
// tb_screen_scan_ctrl: scoreboard bench for the panel scan sequencer (BPC=4, BASE_TIME=32).
module tb_screen_scan_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int compared = 0;
  int mismatched = 0;
  logic [23:0] mem [0:1023];
  logic [5:0] rgb_q [$];
  logic [3:0] addr_q [$];
  always #5 clk = ~clk;
  screen_scan_ctrl_if #(.BPC(4)) bus();
  screen_scan_ctrl #(.BPC(4), .BASE_TIME(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always @(posedge clk) if (bus.fb_rd) bus.fb_rdata <= mem[bus.fb_addr];

  function automatic logic [5:0] pix_exp(input int row, input int col, input int plane);
    logic [23:0] w;
    logic [5:0] v;
    w = mem[row*32 + col];
    for (int k = 0; k < 6; k++) v[k] = w[k*4 + plane];
    return v;
  endfunction

  task automatic fill(input logic [23:0] v);
    for (int a = 0; a < 1024; a++) mem[a] = v;
  endtask

  // Entered at a negedge; returns at the negedge of the following FETCH without consuming it.
  task automatic run_plane(input int row, input int plane);
    int clks = 0, rds = 0, lows = 0, n = 0;
    bit pclk = 0, latched = 0;
    logic [5:0] e;
    for (int c = 0; c < 32; c++) rgb_q.push_back(pix_exp(row, c, plane));
    forever begin
      if (latched && lows > 0 && bus.panel_oe_n) break;
      if (n++ > 1000) begin
        compared++; mismatched++;
        $display("FAIL plane_timeout row=%0d plane=%0d", row, plane);
        rgb_q.delete();
        return;
      end
      if (bus.fb_rd) rds++;
      if (bus.panel_clk && !pclk) begin
        clks++;
        if (rgb_q.size() > 0) begin
          e = rgb_q.pop_front();
          compared++;
          if (bus.panel_rgb !== e) begin
            mismatched++;
            $display("FAIL rgb row=%0d plane=%0d col=%0d got=%h exp=%h", row, plane, clks - 1, bus.panel_rgb, e);
          end
        end
      end
      pclk = bus.panel_clk;
      if (bus.panel_lat) latched = 1;
      if (!bus.panel_oe_n) begin
        lows++;
        if (lows == 1) begin
          compared++;
          if (!latched || bus.panel_addr !== 4'(row)) begin
            mismatched++;
            $display("FAIL disp_addr row=%0d plane=%0d got=%0d latched=%0d", row, plane, bus.panel_addr, latched);
          end
        end
      end
      @(negedge clk);
    end
    compared++;
    if (clks != 32 || rds != 32 || lows != (32 << plane) || rgb_q.size() != 0) begin
      mismatched++;
      $display("FAIL plane_timing row=%0d plane=%0d clks=%0d/32 rds=%0d/32 oe_low=%0d/%0d left=%0d",
               row, plane, clks, rds, lows, 32 << plane, rgb_q.size());
      rgb_q.delete();
    end
  endtask

  task automatic restart();
    bus.enable = 1'b0;
    @(negedge clk);
    bus.enable = 1'b1;
  endtask

  task automatic test_reset();
    logic [$bits(bus.fb_addr)-1:0] za;
    za = '0;
    reset = 1'b1;
    bus.enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compared++;
      if ({bus.fb_rd, bus.fb_addr, bus.panel_rgb, bus.panel_addr, bus.panel_clk, bus.panel_lat, bus.frame_done}
          !== {1'b0, za, 6'd0, 4'd0, 3'b000}) begin
        mismatched++;
        $display("FAIL reset_outputs cycle=%0d rd=%b addr=%h rgb=%h paddr=%h clk=%b lat=%b fd=%b", i,
                 bus.fb_rd, bus.fb_addr, bus.panel_rgb, bus.panel_addr, bus.panel_clk, bus.panel_lat, bus.frame_done);
      end
      compared++;
      if (bus.panel_oe_n !== 1'b1) begin
        mismatched++;
        $display("FAIL reset_oe_n cycle=%0d got=%b exp=1", i, bus.panel_oe_n);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_all_on();
    fill(24'hFFFFFF);
    restart();
    for (int p = 0; p < 4; p++) run_plane(0, p);
  endtask

  task automatic test_single_pixel();
    fill(24'h0);
    mem[3*32 + 7] = 24'h000500;
    restart();
    for (int r = 0; r < 4; r++)
      for (int p = 0; p < 4; p++) run_plane(r, p);
  endtask

  task automatic test_enable_drop();
    int n;
    repeat (20) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.panel_oe_n !== 1'b1 || bus.fb_rd !== 1'b0 || bus.panel_clk !== 1'b0) begin
      mismatched++;
      $display("FAIL enable_drop oe_n=%b rd=%b pclk=%b exp 1/0/0", bus.panel_oe_n, bus.fb_rd, bus.panel_clk);
    end
    bus.enable = 1'b1;
    for (int p = 0; p < 4; p++) run_plane(0, p);
    run_plane(1, 0);
    n = 0;
    while (bus.panel_oe_n && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.panel_oe_n !== 1'b1 || bus.fb_rd !== 1'b0 || bus.panel_addr !== 4'd0) begin
      mismatched++;
      $display("FAIL reset_mid_display oe_n=%b rd=%b paddr=%0d exp 1/0/0", bus.panel_oe_n, bus.fb_rd, bus.panel_addr);
    end
    reset = 1'b0;
    @(negedge clk);
    run_plane(0, 0);
  endtask

  task automatic test_full_frame();
    int n = 0, cyc = 0, rds = 0;
    bit poe = 1;
    logic [3:0] e;
    fill(24'h0);
    restart();
    while (bus.frame_done !== 1'b1 && n < 13000) begin
      @(negedge clk);
      n++;
    end
    for (int r = 0; r < 16; r++) repeat (4) addr_q.push_back(4'(r));
    do begin
      @(negedge clk);
      cyc++;
      if (bus.fb_rd) rds++;
      if (!bus.panel_oe_n && poe && addr_q.size() > 0) begin
        e = addr_q.pop_front();
        compared++;
        if (bus.panel_addr !== e) begin
          mismatched++;
          $display("FAIL frame_addr got=%0d exp=%0d", bus.panel_addr, e);
        end
      end
      poe = bus.panel_oe_n;
    end while (bus.frame_done !== 1'b1 && cyc < 13000);
    compared++;
    if (cyc != 11904 || rds != 2048 || addr_q.size() != 0) begin
      mismatched++;
      $display("FAIL frame_period cycles=%0d/11904 fb_rd=%0d/2048 addr_left=%0d", cyc, rds, addr_q.size());
    end
    addr_q.delete();
  endtask

`ifdef SCREEN_DBUF_EN
  task automatic test_dbuf();
    int n = 0, bad = 0, acks = 0;
    bit seen = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    bus.swap_req = 1'b1;
    @(negedge clk);
    bus.swap_req = 1'b0;
    repeat (300) @(negedge clk);
    bus.swap_req = 1'b1;
    @(negedge clk);
    bus.swap_req = 1'b0;
    while (bus.frame_done !== 1'b1 && n < 13000) begin
      if (bus.fb_rd && bus.fb_addr[9] !== 1'b0) bad++;
      if (bus.swap_ack) acks++;
      @(negedge clk);
      n++;
    end
    compared++;
    if (bus.swap_ack !== 1'b1 || bad != 0 || acks != 0) begin
      mismatched++;
      $display("FAIL dbuf_swap ack=%b early_front=%0d early_acks=%0d exp 1/0/0", bus.swap_ack, bad, acks);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.fb_rd && !seen) begin
        seen = 1;
        compared++;
        if (bus.fb_addr[9] !== 1'b1) begin
          mismatched++;
          $display("FAIL dbuf_front got=%b exp=1", bus.fb_addr[9]);
        end
      end
    end while (bus.frame_done !== 1'b1 && n < 13000);
    compared++;
    if (bus.swap_ack !== 1'b0) begin
      mismatched++;
      $display("FAIL dbuf_merge second_ack=%b exp=0", bus.swap_ack);
    end
  endtask
`endif

  initial begin
    bus.enable = 1'b1;
    bus.fb_rdata = '0;
`ifdef SCREEN_DBUF_EN
    bus.swap_req = 1'b0;
`endif
    fill(24'h0);
    test_reset();
    test_all_on();
    test_single_pixel();
    test_enable_drop();
    test_full_frame();
`ifdef SCREEN_DBUF_EN
    test_dbuf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
